// File: rtl/fixed_float_denormalizer_pkg.sv
// Shared single-precision float format constants, FSM encodings and packing
// helpers used by the fixed<->float conversion blocks.
package fixed_float_denormalizer_pkg;

  localparam int FLOAT_EXP_W   = 8;
  localparam int FLOAT_FRAC_W  = 23;
  localparam int FLOAT_MANT_W  = FLOAT_FRAC_W + 1;
  localparam int FLOAT_BIAS    = 127;
  localparam int FLOAT_EXP_MAX = 255;

  // Signed working width for the biased exponent; leaves headroom for SCALE_EXP.
  localparam int EXP_CALC_W = 12;

  localparam logic [FLOAT_EXP_W-1:0] FLOAT_EXP_INF = '1;
  localparam logic [31:0]            FLOAT_ZERO    = 32'h0000_0000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_ABS     = 3'd2;
  localparam logic [2:0] ST_NORM    = 3'd3;
  localparam logic [2:0] ST_ROUND   = 3'd4;
  localparam logic [2:0] ST_PACK    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef struct packed {
    logic                    sign;
    logic [FLOAT_EXP_W-1:0]  exp;
    logic [FLOAT_FRAC_W-1:0] frac;
  } float_t;

  function automatic float_t float_inf(input logic sign);
    float_t f;
    f.sign = sign;
    f.exp  = FLOAT_EXP_INF;
    f.frac = '0;
    return f;
  endfunction

  function automatic float_t float_signed_zero(input logic sign);
    float_t f;
    f.sign = sign;
    f.exp  = '0;
    f.frac = '0;
    return f;
  endfunction

endpackage

// File: rtl/fixed_float_denormalizer_lod.sv
// Combinational leading-one detector: position of the highest set bit of a
// 32-bit word, plus a flag for an all-zero word.
module leading_one_detector_32 (
  input  logic [31:0] vec_i,
  output logic [4:0]  pos_o,
  output logic        zero_o
);

  always_comb begin
    // NOTE: every combinationally driven signal gets a default first, so no latch is inferred.
    pos_o  = '0;
    zero_o = (vec_i == '0);
    // Ascending scan: the last hit is the most significant one.
    for (int i = 0; i < 32; i++) begin
      if (vec_i[i]) pos_o = 5'(i);
    end
  end

endmodule

// File: rtl/fixed_float_denormalizer.sv
// Multi-cycle converter from signed Q5.FRAC_BITS fixed point to IEEE-754 single
// precision with round-to-nearest-even, a power-of-two scale and O/U flags.
module fixed_float_denormalizer
  import fixed_float_denormalizer_pkg::*;
#(
  parameter int FRAC_BITS = 26,
  parameter int SCALE_EXP = 0
) (
  input  logic        CLK,
  input  logic        RST_FF,
  input  logic        Begin_FSM_FF,
  input  logic [31:0] FIXED,
  output logic        ACK_FF,
  output logic [31:0] RESULT,
  output logic        O_F,
  output logic        U_F
);

  logic [2:0]                     state_q, state_d;
  logic [31:0]                    fixed_q, fixed_d;
  logic                           sign_q, sign_d;
  logic [31:0]                    mag_q, mag_d;
  logic                           zero_q, zero_d;
  logic signed [EXP_CALC_W-1:0]   exp_q, exp_d;
  logic [FLOAT_MANT_W-1:0]        mant_q, mant_d;
  logic                           guard_q, guard_d;
  logic                           sticky_q, sticky_d;
  float_t                         result_q, result_d;
  logic                           ack_q, ack_d;
  logic                           of_q, of_d;
  logic                           uf_q, uf_d;

  logic [4:0]                     lead_pos;
  logic                           lead_zero;
  logic signed [EXP_CALC_W-1:0]   exp_norm;
  logic [4:0]                     rsh;
  logic [31:0]                    sticky_mask;
  logic                           round_up;
  logic [FLOAT_MANT_W:0]          mant_inc;

  leading_one_detector_32 u_lod (
    .vec_i  (mag_q),
    .pos_o  (lead_pos),
    .zero_o (lead_zero)
  );

  always_comb begin
    state_d  = state_q;
    fixed_d  = fixed_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    zero_d   = zero_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ack_d    = 1'b0;
    of_d     = of_q;
    uf_d     = uf_q;

    exp_norm    = EXP_CALC_W'(int'(lead_pos) - FRAC_BITS + SCALE_EXP + FLOAT_BIAS);
    rsh         = lead_pos - 5'd23;
    // Bits below the guard position; only meaningful when lead_pos > 23.
    sticky_mask = ((32'd1 << rsh) >> 1) - 32'd1;
    round_up    = guard_q & (sticky_q | mant_q[0]);
    mant_inc    = {1'b0, mant_q} + {{FLOAT_MANT_W{1'b0}}, round_up};

    case (state_q)
      ST_IDLE: begin
        if (Begin_FSM_FF) begin
          state_d = ST_CAPTURE;
          fixed_d = FIXED;
        end
      end
      ST_CAPTURE: state_d = ST_ABS;
      ST_ABS: begin
        // Unsigned negate: -2^31 maps to 0x8000_0000 without overflow.
        sign_d  = fixed_q[31];
        mag_d   = fixed_q[31] ? (~fixed_q + 32'd1) : fixed_q;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        zero_d = lead_zero;
        exp_d  = exp_norm;
        if (lead_pos <= 5'd23) begin
          mant_d   = FLOAT_MANT_W'(mag_q << (5'd23 - lead_pos));
          guard_d  = 1'b0;
          sticky_d = 1'b0;
        end else begin
          mant_d   = FLOAT_MANT_W'(mag_q >> rsh);
          guard_d  = mag_q[rsh - 5'd1];
          sticky_d = |(mag_q & sticky_mask);
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (mant_inc[FLOAT_MANT_W]) begin
          mant_d = mant_inc[FLOAT_MANT_W:1];
          exp_d  = exp_q + EXP_CALC_W'(1);
        end else begin
          mant_d = mant_inc[FLOAT_MANT_W-1:0];
        end
        state_d = ST_ROUND + 3'd1;
      end
      ST_PACK: begin
        ack_d = 1'b1;
        of_d  = 1'b0;
        uf_d  = 1'b0;
        if (zero_q) begin
          result_d = float_t'(FLOAT_ZERO);
        end else if (exp_q >= EXP_CALC_W'(FLOAT_EXP_MAX)) begin
          result_d = float_inf(sign_q);
          of_d     = 1'b1;
        end else if (exp_q <= EXP_CALC_W'(0)) begin
          result_d = float_signed_zero(sign_q);
          uf_d     = 1'b1;
        end else begin
          result_d.sign = sign_q;
          result_d.exp  = exp_q[FLOAT_EXP_W-1:0];
          result_d.frac = mant_q[FLOAT_FRAC_W-1:0];
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: the datapath registers are reset as well so no X ever reaches RESULT.
    if (RST_FF) begin
      state_q  <= ST_IDLE;
      fixed_q  <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      zero_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ack_q    <= 1'b0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      fixed_q  <= fixed_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      zero_q   <= zero_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ack_q    <= ack_d;
      of_q     <= of_d;
      uf_q     <= uf_d;
    end
  end

  assign ACK_FF = ack_q;
  assign RESULT = result_q;
  assign O_F    = of_q;
  assign U_F    = uf_q;

endmodule

// File: tb/tb_fixed_float_denormalizer.sv
// Bench for fixed_float_denormalizer: three instances (scale 0, +200, -200) driven
// in parallel and compared against a real-arithmetic reference model.
module tb_fixed_float_denormalizer;

  logic        clk = 1'b0;
  logic        rst_ff;
  logic        begin_ff;
  logic [31:0] fixed_in;
  logic        ack [3];
  logic [31:0] res [3];
  logic        of_f [3];
  logic        uf_f [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fixed_float_denormalizer #(.FRAC_BITS(26), .SCALE_EXP(0)) dut (
    .CLK(clk), .RST_FF(rst_ff), .Begin_FSM_FF(begin_ff), .FIXED(fixed_in),
    .ACK_FF(ack[0]), .RESULT(res[0]), .O_F(of_f[0]), .U_F(uf_f[0]));

  fixed_float_denormalizer #(.FRAC_BITS(26), .SCALE_EXP(200)) dut_ovf (
    .CLK(clk), .RST_FF(rst_ff), .Begin_FSM_FF(begin_ff), .FIXED(fixed_in),
    .ACK_FF(ack[1]), .RESULT(res[1]), .O_F(of_f[1]), .U_F(uf_f[1]));

  fixed_float_denormalizer #(.FRAC_BITS(26), .SCALE_EXP(-200)) dut_unf (
    .CLK(clk), .RST_FF(rst_ff), .Begin_FSM_FF(begin_ff), .FIXED(fixed_in),
    .ACK_FF(ack[2]), .RESULT(res[2]), .O_F(of_f[2]), .U_F(uf_f[2]));

  function automatic int scale_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 200 : -200);
  endfunction

  // Reference: exact real value m * 2^-26, rounded to 24 significant bits (RNE).
  function automatic void ref_model(input logic [31:0] x, input int scale,
                                    output logic [31:0] r, output logic of, output logic uf);
    longint m;
    longint q;
    int     p;
    int     e;
    real    scaled;
    real    rem;
    r  = '0;
    of = 1'b0;
    uf = 1'b0;
    m  = longint'($signed(x));
    if (m < 0) m = -m;
    if (m == 0) return;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    scaled = real'(m) * (2.0 ** (23 - p));
    q      = longint'($floor(scaled));
    rem    = scaled - real'(q);
    if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
    if (q == (longint'(1) << 24)) begin
      q = q >>> 1;
      p++;
    end
    e = p - 26 + scale + 127;
    if (e >= 255) begin
      r  = {x[31], 8'hFF, 23'd0};
      of = 1'b1;
    end else if (e <= 0) begin
      r  = {x[31], 31'd0};
      uf = 1'b1;
    end else begin
      r = {x[31], e[7:0], q[22:0]};
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/ack%0d", tag, i), 32'(ack[i]), 32'd0);
      check($sformatf("%s/res%0d", tag, i), res[i], 32'd0);
      check($sformatf("%s/of%0d", tag, i), 32'(of_f[i]), 32'd0);
      check($sformatf("%s/uf%0d", tag, i), 32'(uf_f[i]), 32'd0);
    end
  endtask

  // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle.
  task automatic run_conv(input logic [31:0] x, input string tag);
    logic [31:0] er;
    logic        eo;
    logic        eu;
    fixed_in = x;
    begin_ff = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin_ff = 1'b0;
      check($sformatf("%s/ack_c%0d", tag, cyc), 32'(ack[0]), 32'(cyc == 6));
      if (cyc == 6) begin
        for (int i = 0; i < 3; i++) begin
          ref_model(x, scale_of(i), er, eo, eu);
          if (i != 0) check($sformatf("%s/ack%0d", tag, i), 32'(ack[i]), 32'd1);
          check($sformatf("%s/res%0d", tag, i), res[i], er);
          check($sformatf("%s/of%0d", tag, i), 32'(of_f[i]), 32'(eo));
          check($sformatf("%s/uf%0d", tag, i), 32'(uf_f[i]), 32'(eu));
        end
      end
    end
    ref_model(x, 0, er, eo, eu);
    check($sformatf("%s/held", tag), res[0], er);
  endtask

  logic [31:0] dir_in  [8] = '{32'h0400_0000, 32'hFC00_0000, 32'h8000_0000, 32'h0000_0000,
                               32'h0100_0001, 32'h0100_0003, 32'h7FFF_FFFF, 32'h0000_0001};
  logic [31:0] dir_exp [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'hC200_0000, 32'h0000_0000,
                               32'h3E80_0000, 32'h3E80_0002, 32'h4200_0000, 32'h3280_0000};

  initial begin
    int          ack_seen;
    int          ack_cycles[$];
    logic [31:0] rnd;
    int          sh;

    rst_ff   = 1'b1;
    begin_ff = 1'b0;
    fixed_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_ff = 1'b0;

    // Directed vectors with known single-precision encodings.
    for (int k = 0; k < 8; k++) begin
      run_conv(dir_in[k], $sformatf("dir%0d", k));
      check($sformatf("dir%0d/const", k), res[0], dir_exp[k]);
      check($sformatf("dir%0d/of", k), 32'(of_f[0]), 32'd0);
      check($sformatf("dir%0d/uf", k), 32'(uf_f[0]), 32'd0);
    end

    // Exponent extremes via the scaled instances.
    run_conv(32'h0400_0000, "extreme");
    check("extreme/ovf_res", res[1], 32'h7F80_0000);
    check("extreme/ovf_flag", 32'(of_f[1]), 32'd1);
    check("extreme/unf_res", res[2], 32'h0000_0000);
    check("extreme/unf_flag", 32'(uf_f[2]), 32'd1);

    // Reset while in NORM aborts the conversion.
    fixed_in = 32'h0400_0000;
    begin_ff = 1'b1;
    @(posedge clk);
    @(negedge clk);
    begin_ff = 1'b0;
    repeat (2) @(negedge clk);
    rst_ff = 1'b1;
    @(negedge clk);
    rst_ff = 1'b0;
    check_outputs_zero("rst_norm");
    ack_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[0]) ack_seen++;
    end
    check("rst_norm/no_ack", 32'(ack_seen), 32'd0);

    // Reset wins over a simultaneous start request.
    begin_ff = 1'b1;
    rst_ff   = 1'b1;
    @(negedge clk);
    begin_ff = 1'b0;
    rst_ff   = 1'b0;
    ack_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[0]) ack_seen++;
    end
    check("rst_prio/no_ack", 32'(ack_seen), 32'd0);

    // A start pulse during ROUND is ignored.
    fixed_in = 32'hFC00_0000;
    begin_ff = 1'b1;
    @(posedge clk);
    ack_seen = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin_ff = 1'b0;
      if (cyc == 4) begin_ff = 1'b1;
      if (cyc == 5) begin_ff = 1'b0;
      if (ack[0]) ack_seen++;
    end
    check("round_pulse/ack_count", 32'(ack_seen), 32'd1);
    check("round_pulse/res", res[0], 32'hBF80_0000);

    // Start held high: acknowledges every 7 cycles.
    fixed_in = 32'h0400_0000;
    begin_ff = 1'b1;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      @(negedge clk);
      if (ack[0]) ack_cycles.push_back(cyc);
    end
    begin_ff = 1'b0;
    check("held/ack_count", 32'(ack_cycles.size()), 32'd4);
    for (int k = 0; k < ack_cycles.size() && k < 4; k++)
      check($sformatf("held/ack%0d_cycle", k), 32'(ack_cycles[k]), 32'(6 + 7 * k));
    @(negedge clk);

    // Randomized operands with spread leading-one positions.
    for (int n = 0; n < 40; n++) begin
      rnd = $urandom;
      sh  = $urandom_range(0, 31);
      run_conv(32'($signed(rnd) >>> sh), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_float_denormalizer.md
FIXED_FLOAT_DENORMALIZER -- requirements
Module: fixed_float_denormalizer

Interface
REQ-001 Parameter FRAC_BITS, default 26, SHALL give the fractional bits of the signed two's-complement Q5.26 input.
REQ-002 Parameter SCALE_EXP, default 0, SHALL be a signed power-of-two denormalization factor added to the result exponent.
REQ-003 CLK  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 RST_FF  input  1  SHALL be the synchronous, active-high reset.
REQ-005 Begin_FSM_FF  input  1  SHALL request a conversion when high in IDLE.
REQ-006 FIXED  input  32  SHALL be the signed fixed-point operand, sampled on the accepting edge.
REQ-007 ACK_FF  output  1  SHALL be a one-cycle pulse marking RESULT, O_F and U_F valid.
REQ-008 RESULT  output  32  SHALL be the IEEE-754 single-precision result, held until the next ACK_FF.
REQ-009 O_F  output  1  SHALL flag exponent overflow for the last conversion.
REQ-010 U_F  output  1  SHALL flag exponent underflow for the last conversion.

Function
REQ-011 FSM states SHALL be IDLE, CAPTURE, ABS, NORM, ROUND, PACK, DONE, advancing one state per cycle; DONE returns to IDLE.
REQ-012 IDLE->CAPTURE SHALL occur only when Begin_FSM_FF=1; FIXED is registered on that edge.
REQ-013 ACK_FF SHALL rise exactly 6 cycles after the accepting edge and last exactly one cycle, in DONE.
REQ-014 Begin_FSM_FF SHALL be ignored in all states except IDLE; a level held high restarts a conversion on the cycle after DONE.
REQ-015 ABS SHALL store the sign bit and the 32-bit unsigned magnitude; -2^31 yields magnitude 2^31 without loss.
REQ-016 NORM SHALL locate leading-one position p (0..31) and compute the biased exponent E = p - FRAC_BITS + SCALE_EXP + 127 in at least 10 signed bits.
REQ-017 For p<=23 the mantissa SHALL be the magnitude left-shifted by 23-p; for p>23 it SHALL be right-shifted by p-23, with guard = the first discarded bit and sticky = OR of the rest.
REQ-018 ROUND SHALL apply round-to-nearest-even: increment when guard & (sticky | lsb); a mantissa carry-out SHALL renormalize and increment E.
REQ-019 A zero magnitude SHALL produce RESULT=0x00000000 with O_F=U_F=0.
REQ-020 E>=255 after rounding SHALL produce signed infinity (exponent 0xFF, fraction 0) with O_F=1.
REQ-021 E<=0 SHALL produce signed zero with U_F=1; subnormals are not generated.
REQ-022 PACK SHALL assemble {sign, E[7:0], fraction[22:0]} and update RESULT, O_F and U_F together on the same edge.

Reset
REQ-023 With RST_FF high at a rising edge the FSM SHALL enter IDLE and RESULT, ACK_FF, O_F, U_F SHALL be 0 on the next cycle.
REQ-024 Reset mid-conversion SHALL abort it with no ACK_FF pulse; the conversion is not resumed.
REQ-025 Reset SHALL take priority over Begin_FSM_FF on the same edge.

Structure
REQ-026 FSM state encodings, the IEEE bias (127), the exponent and fraction widths and the infinity/zero constants SHALL reside in the shared float-format package used by the float-to-fixed normalizers.
REQ-027 The leading-one detector SHALL be a single sub-module, leading_one_detector_32, that is combinational, returns p and a zero flag, and contains no registers.

Verification
REQ-028 FIXED=0x04000000 (1.0), Begin_FSM_FF pulse -> ACK_FF 6 cycles later, RESULT=0x3F800000, O_F=U_F=0.
REQ-029 FIXED=0xFC000000 -> 0xBF800000; FIXED=0x80000000 -> 0xC2000000; FIXED=0x00000000 -> 0x00000000.
REQ-030 Rounding: 0x01000001 -> 0x3E800000 (tie, even kept); 0x01000003 -> 0x3E800002 (tie, round up); 0x7FFFFFFF -> 0x42000000 (carry renormalizes).
REQ-031 Extremes: 0x00000001 -> 0x32800000; SCALE_EXP=200 with 1.0 -> 0x7F800000, O_F=1; SCALE_EXP=-200 with 1.0 -> 0x00000000, U_F=1.
REQ-032 Control: RST_FF asserted during NORM -> no ACK_FF and outputs 0; Begin_FSM_FF pulsed during ROUND -> ignored and exactly one ACK_FF; Begin_FSM_FF held high -> back-to-back ACK_FF every 7 cycles.
